// File: rtl/vram_pkg.sv
// Shared constants and elaboration helpers for the banked SPRAM video RAM.
package vram_pkg;

    localparam logic [3:0] MASK_LO = 4'b0011;
    localparam logic [3:0] MASK_HI = 4'b1100;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_VID  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit banks_ok(input int b);
        return (b == 1) || (b == 2) || (b == 4);
    endfunction

endpackage

// File: rtl/vram_arb_spram_bank.sv
// One SB_SPRAM256KA equivalent: 16K x 16, nibble write mask, registered read data.
// STANDBY/SLEEP are tied low and POWEROFF high, so only the access pins remain.
module spram_bank (
    input  logic        clk,
    input  logic [13:0] addr_i,
    input  logic [15:0] din_i,
    input  logic [3:0]  mask_i,
    input  logic        we_i,
    input  logic        cs_i,
    output logic [15:0] dout_o
);

    logic [15:0] mem_q [0:16383];
    logic [15:0] dout_q;

    // Read data only updates on a selected read, as the hard macro does.
    always_ff @(posedge clk) begin
        if (cs_i) begin
            if (we_i) begin
                for (int n = 0; n < 4; n++) begin
                    if (mask_i[n]) mem_q[addr_i][4*n +: 4] <= din_i[4*n +: 4];
                end
            end else begin
                dout_q <= mem_q[addr_i];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/vram_arb_spram.sv
// Banked SPRAM video RAM: one physical access per cycle shared between a byte CPU port
// and a 16-bit video fetch port; video has priority, bounded by a CPU starvation counter.
module vram_arb_spram
    import vram_pkg::*;
#(
    parameter int BANKS    = 1,
    parameter int MAX_WAIT = 4,
    localparam int AW      = 15 + clog2(BANKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_rdy,
    output logic [7:0]    cpu_dout,
    input  logic          vid_req,
    input  logic [AW-2:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [15:0]   vid_dout
);

    localparam int BW = (BANKS > 1) ? clog2(BANKS) : 1;

    if (!banks_ok(BANKS)) begin : g_bad_banks
        $error("vram_arb_spram: BANKS must be 1, 2 or 4");
    end

    logic [BW-1:0] cpu_bank, vid_bank, sel_bank, bank_q;
    logic [1:0]    gnt_q, gnt_d;
    logic [3:0]    starve_q, starve_d;
    logic          bsel_q, wr_q;
    logic          vid_gnt, cpu_gnt, cpu_busy, starved, acc_we;
    logic [13:0]   word;
    logic [15:0]   rd_word;
    logic [BANKS-1:0][15:0] bank_dout;

    if (BANKS > 1) begin : g_bank_sel
        assign cpu_bank = cpu_addr[AW-1:15];
        assign vid_bank = vid_addr[AW-2:14];
    end else begin : g_one_bank
        assign cpu_bank = '0;
        assign vid_bank = '0;
    end

    // The CPU is in flight during its rdy cycle, which blocks a held request from re-issuing.
    assign cpu_busy = (gnt_q == GNT_CPU);
    assign starved  = (starve_q >= 4'(MAX_WAIT));
    assign vid_gnt  = !reset && vid_req && !starved;
    assign cpu_gnt  = !reset && !vid_gnt && cpu_req && !cpu_busy;
    assign vid_ack  = vid_gnt;

    assign sel_bank = vid_gnt ? vid_bank : cpu_bank;
    assign word     = vid_gnt ? vid_addr[13:0] : cpu_addr[14:1];
    assign acc_we   = cpu_gnt && cpu_we;

    always_comb begin
        starve_d = starve_q;
        if (cpu_gnt)
            starve_d = 4'd0;
        else if (cpu_req && !cpu_busy && !starved)
            starve_d = starve_q + 4'd1;
    end

    always_comb begin
        gnt_d = GNT_NONE;
        if (vid_gnt)
            gnt_d = GNT_VID;
        else if (cpu_gnt)
            gnt_d = GNT_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q    <= GNT_NONE;
            starve_q <= 4'd0;
            bank_q   <= '0;
            bsel_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            starve_q <= starve_d;
            bank_q   <= sel_bank;
            bsel_q   <= cpu_addr[0];
            wr_q     <= acc_we;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        spram_bank u_bank (
            .clk    (clk),
            .addr_i (word),
            .din_i  ({cpu_din, cpu_din}),
            .mask_i (cpu_addr[0] ? MASK_HI : MASK_LO),
            .we_i   (acc_we),
            .cs_i   ((vid_gnt || cpu_gnt) && (sel_bank == BW'(b))),
            .dout_o (bank_dout[b])
        );
    end

    // Gating with reset drops the completion pulse of an access interrupted by reset.
    assign rd_word   = bank_dout[bank_q];
    assign cpu_rdy   = !reset && (gnt_q == GNT_CPU);
    assign vid_valid = !reset && (gnt_q == GNT_VID);
    assign cpu_dout  = wr_q ? 8'h00 : (bsel_q ? rd_word[15:8] : rd_word[7:0]);
    assign vid_dout  = rd_word;

endmodule

// File: tb/tb_vram_arb_spram.sv
// Directed bench for vram_arb_spram with 4 banks and MAX_WAIT=4.
module tb_vram_arb_spram;

    localparam int BANKS    = 4;
    localparam int MAX_WAIT = 4;
    localparam int AW       = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = 8'h00;
    logic          cpu_rdy;
    logic [7:0]    cpu_dout;
    logic          vid_req = 1'b0;
    logic [AW-2:0] vid_addr = '0;
    logic          vid_ack, vid_valid;
    logic [15:0]   vid_dout;

    int errs = 0;
    int checks = 0;

    vram_arb_spram #(.BANKS(BANKS), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_rdy(cpu_rdy), .cpu_dout(cpu_dout),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_dout(vid_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Registered outputs are checked right after this; inputs are driven after it.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_din = d;
    endtask

    initial begin
        // Reset: vid_ack held off even with a request pending
        vid_req = 1'b1;
        tick(); #1;
        chk("rst_ack", 16'(vid_ack), 16'h0);
        tick();
        chk("rst_rdy", 16'(cpu_rdy), 16'h0);
        chk("rst_valid", 16'(vid_valid), 16'h0);
        vid_req = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_starve", 16'(dut.starve_q), 16'h0);

        // Write A5 to 0x0001, read it back, then fetch word 0 on video
        cpu_set(1, 1, 17'h00001, 8'hA5);
        #1 chk("wr_ack", 16'(vid_ack), 16'h0);
        tick();
        chk("wr_rdy", 16'(cpu_rdy), 16'h1);
        cpu_set(0, 0, 17'h00001, 8'h00);
        tick();
        chk("wr_rdy_gone", 16'(cpu_rdy), 16'h0);
        cpu_set(1, 0, 17'h00001, 8'h00);
        tick();
        chk("rd_rdy", 16'(cpu_rdy), 16'h1);
        chk("rd_dout", 16'(cpu_dout), 16'hA5);
        cpu_set(0, 0, 17'h0, 8'h00);
        vid_req = 1'b1; vid_addr = 16'h0000;
        #1 chk("vid_ack0", 16'(vid_ack), 16'h1);
        tick();
        chk("vid_valid0", 16'(vid_valid), 16'h1);
        chk("vid_hi_a5", 16'(vid_dout[15:8]), 16'hA5);
        vid_req = 1'b0;

        // Bank separation: 0x11 at 0x00000, 0x22 at 0x18000 (bank 3)
        cpu_set(1, 1, 17'h00000, 8'h11);
        tick();
        chk("b0_wr_rdy", 16'(cpu_rdy), 16'h1);
        cpu_set(0, 0, 17'h0, 8'h00);
        tick();
        cpu_set(1, 1, 17'h18000, 8'h22);
        tick();
        chk("b3_wr_rdy", 16'(cpu_rdy), 16'h1);
        cpu_set(0, 0, 17'h0, 8'h00);
        vid_req = 1'b1; vid_addr = 16'h0000;
        tick();
        chk("b2b_valid0", 16'(vid_valid), 16'h1);
        chk("bank0_word", vid_dout, 16'hA511);
        vid_addr = 16'hC000;
        #1 chk("b2b_ack1", 16'(vid_ack), 16'h1);
        tick();
        chk("b2b_valid1", 16'(vid_valid), 16'h1);
        chk("bank3_lo", 16'(vid_dout[7:0]), 16'h22);
        vid_req = 1'b0;

        // Write then immediate video read of the same word sees the new byte
        cpu_set(1, 1, 17'h00002, 8'h5A);
        tick();
        chk("wf_rdy", 16'(cpu_rdy), 16'h1);
        cpu_set(0, 0, 17'h0, 8'h00);
        vid_req = 1'b1; vid_addr = 16'h0001;
        tick();
        chk("wf_lo", 16'(vid_dout[7:0]), 16'h5A);
        vid_req = 1'b0;
        tick();

        // Starvation: video held high, CPU wins on the 5th cycle
        vid_req = 1'b1; vid_addr = 16'h0000;
        cpu_set(1, 0, 17'h00001, 8'h00);
        for (int i = 0; i < MAX_WAIT; i++) begin
            #1 chk($sformatf("stv_ack%0d", i), 16'(vid_ack), 16'h1);
            chk($sformatf("stv_rdy%0d", i), 16'(cpu_rdy), 16'h0);
            tick();
        end
        #1 chk("stv_ack_low", 16'(vid_ack), 16'h0);
        tick();
        chk("stv_rdy", 16'(cpu_rdy), 16'h1);
        chk("stv_dout", 16'(cpu_dout), 16'hA5);
        chk("stv_cnt0", 16'(dut.starve_q), 16'h0);
        cpu_set(0, 0, 17'h0, 8'h00);
        vid_req = 1'b0;
        tick();

        // Simultaneous requests: video first, CPU when video goes quiet
        vid_req = 1'b1; vid_addr = 16'h0000;
        cpu_set(1, 0, 17'h00000, 8'h00);
        #1 chk("sim_ack", 16'(vid_ack), 16'h1);
        tick();
        chk("sim_no_rdy", 16'(cpu_rdy), 16'h0);
        vid_req = 1'b0;
        #1 chk("sim_ack_off", 16'(vid_ack), 16'h0);
        tick();
        chk("sim_rdy", 16'(cpu_rdy), 16'h1);
        chk("sim_dout", 16'(cpu_dout), 16'h11);
        cpu_set(0, 0, 17'h0, 8'h00);
        tick();

        // Reset the cycle after a read grant: the completion is dropped
        cpu_set(1, 0, 17'h00001, 8'h00);
        tick();
        reset = 1'b1;
        cpu_set(0, 0, 17'h0, 8'h00);
        #1 chk("rmid_rdy", 16'(cpu_rdy), 16'h0);
        tick();
        chk("rmid_rdy2", 16'(cpu_rdy), 16'h0);
        reset = 1'b0;
        tick();
        chk("rpost_rdy", 16'(cpu_rdy), 16'h0);
        chk("rpost_valid", 16'(vid_valid), 16'h0);
        chk("rpost_starve", 16'(dut.starve_q), 16'h0);

        // Held cpu_req: three reads complete on alternate cycles
        cpu_set(1, 0, 17'h00001, 8'h00);
        tick();
        chk("hold_rdy0", 16'(cpu_rdy), 16'h1);
        chk("hold_d0", 16'(cpu_dout), 16'hA5);
        cpu_addr = 17'h00000;
        tick();
        chk("hold_gap0", 16'(cpu_rdy), 16'h0);
        tick();
        chk("hold_rdy1", 16'(cpu_rdy), 16'h1);
        chk("hold_d1", 16'(cpu_dout), 16'h11);
        cpu_addr = 17'h18000;
        tick();
        chk("hold_gap1", 16'(cpu_rdy), 16'h0);
        tick();
        chk("hold_rdy2", 16'(cpu_rdy), 16'h1);
        chk("hold_d2", 16'(cpu_dout), 16'h22);
        cpu_set(0, 0, 17'h0, 8'h00);
        tick();
        chk("hold_end", 16'(cpu_rdy), 16'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vram_arb_spram.md
# vram_arb_spram

Parametrised video RAM built from 1, 2 or 4 SB_SPRAM256KA banks (32/64/128 KB). A single physical port is time-shared between a byte-wide CPU port and a 16-bit word-wide video fetch port. Video has priority, with a bounded starvation guard so CPU accesses always complete. The block sits between the 6502 bus glue and the video scan-out engine, and replaces the single-bank video RAM.

## Interface
Parameters:
- BANKS, 1, number of SPRAM banks; legal values 1, 2, 4.
- MAX_WAIT, 4, number of consecutive cycles the CPU may be denied before it is forced a grant; range 1..15.
- AW, 15+log2(BANKS), CPU byte address width; derived, not overridden.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held stable until cpu_rdy.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  byte address.
- cpu_din  in  8  write data.
- cpu_rdy  out  1  one-cycle pulse: access complete; cpu_dout valid in the same cycle.
- cpu_dout  out  8  read byte.
- vid_req  in  1  video word-fetch request.
- vid_addr  in  AW-1  word address.
- vid_ack  out  1  combinational; vid_req granted this cycle.
- vid_valid  out  1  one-cycle pulse one cycle after vid_ack.
- vid_dout  out  16  fetched word; little-endian (even byte in [7:0]).

## Operation
- Exactly one SPRAM access per cycle. Bank = top log2(BANKS) address bits. Word address = byte address[14:1] within the bank.
- Only the selected bank has CHIPSELECT=1. STANDBY=0, SLEEP=0, POWEROFF=1 on all banks.
- Grant, evaluated each cycle:
  - If vid_req and starve_cnt < MAX_WAIT: grant video.
  - Else if cpu_req and no CPU access is in flight: grant CPU.
- starve_cnt (4 bit):
  - increments when cpu_req is high, no CPU access is in flight, and the CPU is not granted;
  - clears on a CPU grant;
  - saturates at MAX_WAIT.
  - At MAX_WAIT the CPU wins even if vid_req is high; vid_ack stays 0 that cycle.
- CPU write: DATAIN={din,din}, MASKWREN = addr[0] ? 4'b1100 : 4'b0011, WREN=1.
- CPU read and video read: WREN=0.
- Pipeline registers (captured on the grant cycle):
  - who was granted;
  - bank index;
  - byte select (cpu_addr[0]);
  - CPU write flag.
- Return path:
  - cpu_dout = byte-selected DATAOUT of the registered bank.
  - vid_dout = full DATAOUT of the registered bank.
- A CPU access is in flight from its grant cycle until its cpu_rdy cycle. The CPU is not re-granted in the cpu_rdy cycle, so a held cpu_req cannot double-issue.
- Writes also pulse cpu_rdy one cycle after grant; cpu_dout is don't-care then.
- cpu_addr or cpu_we changing while cpu_req is high and before cpu_rdy: unsupported.

## Timing
- Reset values: cpu_rdy=0, vid_valid=0, vid_ack=0 while reset is high, starve_cnt=0, all pipeline registers 0, no access in flight.
- Reset mid-access: the in-flight access is dropped; no rdy or valid pulse follows. SPRAM contents are undefined only for a write issued in the reset cycle.
- Latency:
  - CPU: grant in cycle N, cpu_rdy in N+1. Minimum request-to-rdy is 1 cycle; maximum is MAX_WAIT+1 cycles.
  - Video: vid_ack in N, vid_valid and vid_dout in N+1. Back-to-back video grants give one word per cycle.
- Simultaneous vid_req and cpu_req with starve_cnt < MAX_WAIT: video wins.
- A CPU write followed by a video read of the same word in the next cycle returns the new data.

## Structure
- Package vram_pkg:
  - legal BANKS check function;
  - clog2 helper;
  - mask constants MASK_LO=4'b0011, MASK_HI=4'b1100;
  - grant encoding GNT_NONE, GNT_VID, GNT_CPU.
- One sub-module, spram_bank: wraps one SB_SPRAM256KA with addr/din/mask/we/cs inputs and a dout output. It is instantiated BANKS times via generate.
- Arbiter, starvation counter and return mux live in the top module.

## Test plan
- CPU write of 0xA5 to 0x0001, then CPU read of 0x0001 → cpu_rdy one cycle after each grant; cpu_dout=0xA5. Video read of word 0x0000 → vid_dout[15:8]=0xA5.
- BANKS=4: write 0x11 to 0x00000 and 0x22 to 0x18000, then video read of words 0x0000 and 0xC000 → 0x??11 and 0x??22; no aliasing between banks.
- vid_req held high continuously, cpu_req read asserted, MAX_WAIT=4 → vid_ack low on exactly the 5th cycle; cpu_rdy the cycle after; starve_cnt returns to 0.
- Simultaneous requests with starve_cnt=0 → vid_ack=1, cpu_rdy not asserted that cycle; the CPU is served on the first cycle vid_req is low.
- Reset asserted in the cycle after a CPU read grant → no cpu_rdy pulse. After reset is released, cpu_rdy=0, vid_valid=0, starve_cnt=0.
- cpu_req held high for 3 back-to-back reads at distinct addresses, vid_req=0 → exactly one cpu_rdy per access, on alternate cycles.
